// File: rtl/cmul_acc_8b_pkg.sv
// Shared math package for the constant-multiplier datapath: operation codes
// and the frame accumulator's control state type.
package cmul_acc_8b_pkg;

    localparam logic [1:0] MATH_OP_ADD = 2'd0;
    localparam logic [1:0] MATH_OP_SUB = 2'd1;
    localparam logic [1:0] MATH_OP_MUL = 2'd2;
    localparam logic [1:0] MATH_OP_ACC = 2'd3;

    // IDLE: no partial sum, ACC: partial sum held, HOLD: result presented
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

endpackage

// File: rtl/cmul_acc_8b.sv
// Frame accumulator: sums product samples until in_last_i or ACC_LEN samples,
// then presents the sum and sample count on a valid/ready output.
module cmul_acc_8b
    import cmul_acc_8b_pkg::*;
#(
    parameter  int C_SIG   = 0,
    parameter  int I_WIDTH = 14,
    parameter  int ACC_LEN = 16,
    localparam int O_WIDTH = I_WIDTH + $clog2(ACC_LEN),
    localparam int L_WIDTH = $clog2(ACC_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [I_WIDTH-1:0] in_data_i,
    input  logic               in_valid_i,
    input  logic               in_last_i,
    output logic               in_ready_o,
    output logic [O_WIDTH-1:0] out_data_o,
    output logic [L_WIDTH-1:0] out_len_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
);

    localparam logic [L_WIDTH-1:0] LEN_ONE = L_WIDTH'(1);
    localparam logic [L_WIDTH-1:0] LEN_MAX = L_WIDTH'(ACC_LEN);

    acc_state_e         state_reg;
    logic [O_WIDTH-1:0] acc_reg;
    logic [L_WIDTH-1:0] cnt_reg;
    logic               valid_reg;

    logic [O_WIDTH-1:0] ext_data;
    logic [L_WIDTH-1:0] cnt_inc;
    logic               accept;
    logic               hold_xfer;

    generate
        if (C_SIG != 0) begin : g_sext
            assign ext_data = {{(O_WIDTH - I_WIDTH){in_data_i[I_WIDTH-1]}}, in_data_i};
        end else begin : g_zext
            assign ext_data = {{(O_WIDTH - I_WIDTH){1'b0}}, in_data_i};
        end
    endgenerate

    // Only out_ready_i reaches in_ready_o combinationally; everything else is registered state.
    assign in_ready_o = (state_reg != ST_HOLD) || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign hold_xfer  = (state_reg == ST_HOLD) && out_ready_i;
    assign cnt_inc    = cnt_reg + LEN_ONE;

    assign out_data_o  = acc_reg;
    assign out_len_o   = cnt_reg;
    assign out_valid_o = valid_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_ACC: begin
                    if (accept) begin
                        acc_reg <= acc_reg + ext_data;
                        cnt_reg <= cnt_inc;
                        if (in_last_i || (cnt_inc == LEN_MAX)) begin
                            state_reg <= ST_HOLD;
                            valid_reg <= 1'b1;
                        end
                    end
                end
                // IDLE and HOLD-with-transfer share the frame-start path, so a
                // result handed off while a sample arrives costs no bubble.
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        acc_reg <= ext_data;
                        cnt_reg <= LEN_ONE;
                        if (in_last_i || (LEN_ONE == LEN_MAX)) begin
                            state_reg <= ST_HOLD;
                            valid_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_ACC;
                            valid_reg <= 1'b0;
                        end
                    end else if (hold_xfer) begin
                        state_reg <= ST_IDLE;
                        valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmul_acc_8b.sv
// Checks unsigned and signed accumulator instances against a frame-level model
// with directed scenarios followed by randomized traffic.
module tb_cmul_acc_8b;

    localparam int IW = 14;
    localparam int AL = 4;
    localparam int OW = IW + $clog2(AL);
    localparam int LW = $clog2(AL + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready_u, in_ready_s;
    logic [OW-1:0] out_data_u, out_data_s;
    logic [LW-1:0] out_len_u, out_len_s;
    logic          out_valid_u, out_valid_s;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          len;
        logic [15:0] sum_u;
        logic [15:0] sum_s;
    } frame_t;

    frame_t exp_q[$];
    int     cur_len   = 0;
    int     cur_sum_u = 0;
    int     cur_sum_s = 0;

    always #5 clk = ~clk;

    cmul_acc_8b #(.C_SIG(0), .I_WIDTH(IW), .ACC_LEN(AL)) u_dut_u (
        .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_last_i(in_last), .in_ready_o(in_ready_u), .out_data_o(out_data_u),
        .out_len_o(out_len_u), .out_valid_o(out_valid_u), .out_ready_i(out_ready)
    );

    cmul_acc_8b #(.C_SIG(1), .I_WIDTH(IW), .ACC_LEN(AL)) u_dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_last_i(in_last), .in_ready_o(in_ready_s), .out_data_o(out_data_s),
        .out_len_o(out_len_s), .out_valid_o(out_valid_s), .out_ready_i(out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int as_signed(input logic [IW-1:0] d);
        return d[IW-1] ? int'(d) - (1 << IW) : int'(d);
    endfunction

    // One clock cycle: drive inputs, check outputs, then advance the model
    // across the coming rising edge (result handoff before new sample intake).
    task automatic step(input bit v, input bit l, input logic [IW-1:0] d, input bit ordy);
        bit have_res;
        bit exp_ready;
        frame_t f;
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        #1;
        have_res  = (exp_q.size() != 0);
        exp_ready = !have_res || ordy;
        check_eq("in_ready_u", 32'(in_ready_u), 32'(exp_ready));
        check_eq("in_ready_s", 32'(in_ready_s), 32'(exp_ready));
        check_eq("out_valid_u", 32'(out_valid_u), 32'(have_res));
        check_eq("out_valid_s", 32'(out_valid_s), 32'(have_res));
        if (have_res) begin
            check_eq("out_data_u", 32'(out_data_u), 32'(exp_q[0].sum_u));
            check_eq("out_data_s", 32'(out_data_s), 32'(exp_q[0].sum_s));
            check_eq("out_len_u", 32'(out_len_u), 32'(exp_q[0].len));
            check_eq("out_len_s", 32'(out_len_s), 32'(exp_q[0].len));
            if (ordy) begin
                $display("frame out: len=%0d sum_u=0x%04h sum_s=0x%04h",
                         exp_q[0].len, exp_q[0].sum_u, exp_q[0].sum_s);
                void'(exp_q.pop_front());
            end
        end
        if (v && exp_ready) begin
            cur_len++;
            cur_sum_u += int'(d);
            cur_sum_s += as_signed(d);
            if (l || cur_len == AL) begin
                f.len   = cur_len;
                f.sum_u = cur_sum_u[15:0];
                f.sum_s = cur_sum_s[15:0];
                exp_q.push_back(f);
                cur_len   = 0;
                cur_sum_u = 0;
                cur_sum_s = 0;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        check_eq("rst_valid_u", 32'(out_valid_u), 32'd0);
        check_eq("rst_valid_s", 32'(out_valid_s), 32'd0);
        check_eq("rst_data_u", 32'(out_data_u), 32'd0);
        check_eq("rst_data_s", 32'(out_data_s), 32'd0);
        check_eq("rst_len_u", 32'(out_len_u), 32'd0);
        check_eq("rst_len_s", 32'(out_len_s), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        cur_len   = 0;
        cur_sum_u = 0;
        cur_sum_s = 0;
    endtask

    initial begin
        apply_reset();

        // Back-to-back unsigned frame 1,2,3,4, then idle to see valid drop
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, IW'(i), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // All-ones samples: -4 signed, 65532 unsigned
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 14'h3FFF, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Early last, then a fresh frame
        step(1'b1, 1'b0, 14'd5, 1'b1);
        step(1'b1, 1'b1, 14'd7, 1'b1);
        step(1'b1, 1'b1, 14'd3, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Backpressure for three cycles, then release with sample 9
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, IW'(i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 14'd9, 1'b0);
        step(1'b1, 1'b0, 14'd9, 1'b1);
        step(1'b1, 1'b1, 14'd1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset mid-frame discards the partial sum
        step(1'b1, 1'b0, 14'd100, 1'b1);
        step(1'b1, 1'b0, 14'd200, 1'b1);
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 14'd1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Reset while a result is presented and blocked
        step(1'b1, 1'b1, 14'd55, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        apply_reset();
        step(1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [IW-1:0] d;
            d = IW'($urandom);
            if ($urandom_range(0, 7) == 0) d = 14'h2000;
            if ($urandom_range(0, 7) == 0) d = 14'h3FFF;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, d,
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmul_acc_8b.md
CMUL_ACC_8B -- requirements
Module: cmul_acc_8b

Interface
REQ-001 Parameter C_SIG, default 0: 1 = in_data_i is two's complement, 0 = unsigned.
REQ-002 Parameter I_WIDTH, default 14: product width from the upstream constant multiplier.
REQ-003 Parameter ACC_LEN, default 16, legal range 2..1024: maximum number of samples per frame.
REQ-004 Derived O_WIDTH = I_WIDTH + $clog2(ACC_LEN); derived L_WIDTH = $clog2(ACC_LEN+1).
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk_i  input  1  rising-edge clock.
REQ-007 rst_n_i  input  1  asynchronous active-low reset.
REQ-008 in_data_i  input  I_WIDTH  product sample.
REQ-009 in_valid_i  input  1  sample valid.
REQ-010 in_last_i  input  1  final sample of the frame, qualified by in_valid_i.
REQ-011 in_ready_o  output  1  block accepts a sample this cycle.
REQ-012 out_data_o  output  O_WIDTH  frame sum.
REQ-013 out_len_o  output  L_WIDTH  number of samples summed.
REQ-014 out_valid_o  output  1  sum valid.
REQ-015 out_ready_i  input  1  downstream accepts the sum.

Function
REQ-016 A sample is accepted when in_valid_i and in_ready_o are both high at a rising clk_i edge.
REQ-017 Output handshake: transfer occurs when out_valid_o and out_ready_i are both high.
REQ-018 States: IDLE (no partial sum), ACC (partial sum held), HOLD (result presented).
REQ-019 IDLE: in_ready_o=1. On accept, acc = ext(in_data_i) and cnt = 1; go to ACC, or go to HOLD if in_last_i=1.
REQ-020 ACC: in_ready_o=1. On accept, acc += ext(in_data_i) and cnt += 1. Go to HOLD when in_last_i=1 or when cnt reaches ACC_LEN, whichever comes first. No input means stay in ACC.
REQ-021 ext() sign-extends to O_WIDTH when C_SIG=1 and zero-extends when C_SIG=0. Modulo-2^O_WIDTH addition is used, with no saturation. O_WIDTH guarantees no overflow for ACC_LEN samples.
REQ-022 HOLD: out_valid_o=1, out_data_o=acc, out_len_o=cnt. Both outputs are stable until the transfer.
REQ-023 HOLD: in_ready_o = out_ready_i.
REQ-024 HOLD with transfer and a simultaneous accept: the new frame starts in that cycle (acc=sample, cnt=1, next state per REQ-019). This gives zero bubble.
REQ-025 HOLD with transfer and no accept: go to IDLE.
REQ-026 Latency: out_valid_o rises on the clock edge that accepts the frame's final sample, so it is visible in the following cycle.
REQ-027 out_valid_o is registered. in_ready_o is combinational only through out_ready_i.
REQ-028 An ACC_LEN=1-sample frame (in_last_i on the first sample) is legal and gives out_len_o=1.

Reset
REQ-029 While rst_n_i=0: state=IDLE, acc=0, cnt=0, out_valid_o=0, out_data_o=0, out_len_o=0.
REQ-030 in_ready_o follows REQ-019 immediately after reset deasserts.
REQ-031 Reset asserted mid-frame or in HOLD discards the partial or presented result. No output transfer occurs afterwards.

Structure
REQ-032 The state enum type (IDLE/ACC/HOLD) belongs in the shared math package, alongside the existing math operation constants.
REQ-033 Single module; no sub-module is required. Counter and accumulator are inline registers.

Verification (ACC_LEN=4, I_WIDTH=14, out_ready_i=1 unless stated)
REQ-034 Unsigned back-to-back frame: 1,2,3,4 -> out_data_o=10 and out_len_o=4, valid for exactly one cycle after the 4th accept.
REQ-035 C_SIG=1 frame: 0x3FFF x4 -> out_data_o=0xFFFC (-4). The same stimulus with C_SIG=0 -> 0xFFFC (65532), with no overflow.
REQ-036 Early last: 5, then 7 with in_last_i=1 -> out_data_o=12, out_len_o=2. The next frame starts from zero.
REQ-037 Backpressure: out_ready_i low for 3 cycles in HOLD -> out_data_o held, in_ready_o=0, no samples lost. On release with in_valid_i=1 and sample 9, the new frame starts that same cycle.
REQ-038 Reset mid-frame after samples 100,200, then frame 1,1,1,1 -> out_data_o=4, with no output before the reset.
